// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   XLEN / REG_AW / NREG : datapath width, register index width, register count
//   arb_state_e          : starvation FSM states
//   wr_req_t             : one pending register-file write {rd, data}
//   reg_busy()           : scoreboard lookup that treats x0 as never busy
package rf_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREG   = 32;

    typedef enum logic [1:0] {
        IDLE,   // no LLU result waiting
        WAIT,   // LLU result waiting, counting denied cycles
        FORCE   // WB is held off for one cycle so the FIFO head drains
    } arb_state_e;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wr_req_t;

    // x0 is hardwired, so it can never create a hazard.
    function automatic logic reg_busy(input logic [NREG-1:0]   busy,
                                      input logic [REG_AW-1:0] idx);
        return (idx != '0) && busy[idx];
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of all pipeline-facing signals of the write-port arbiter.
//   master : pipeline side (WB stage, LLU, decode, register file sink)
//   slave  : the arbiter itself
// Groups: WB result (wb_valid/wb_rd/wb_data, wb_hold back),
//         LLU issue (iss_valid/iss_rd), LLU result (llu_valid/llu_rd/llu_data,
//         llu_ready back), decode hazard query (dec_rs1/rs2/rd, dec_stall back),
//         register-file write port (rf_regwrite/rf_addr_write/rf_data_in).
interface rf_wb_arbiter_if;

    logic                       wb_valid;
    logic [rf_pkg::REG_AW-1:0]  wb_rd;
    logic [rf_pkg::XLEN-1:0]    wb_data;
    logic                       wb_hold;

    logic                       iss_valid;
    logic [rf_pkg::REG_AW-1:0]  iss_rd;

    logic                       llu_valid;
    logic [rf_pkg::REG_AW-1:0]  llu_rd;
    logic [rf_pkg::XLEN-1:0]    llu_data;
    logic                       llu_ready;

    logic [rf_pkg::REG_AW-1:0]  dec_rs1;
    logic [rf_pkg::REG_AW-1:0]  dec_rs2;
    logic [rf_pkg::REG_AW-1:0]  dec_rd;
    logic                       dec_stall;

    logic                       rf_regwrite;
    logic [rf_pkg::REG_AW-1:0]  rf_addr_write;
    logic [rf_pkg::XLEN-1:0]    rf_data_in;

    modport master (
        output wb_valid, wb_rd, wb_data,
        output iss_valid, iss_rd,
        output llu_valid, llu_rd, llu_data,
        output dec_rs1, dec_rs2, dec_rd,
        input  wb_hold, llu_ready, dec_stall,
        input  rf_regwrite, rf_addr_write, rf_data_in
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data,
        input  iss_valid, iss_rd,
        input  llu_valid, llu_rd, llu_data,
        input  dec_rs1, dec_rs2, dec_rd,
        output wb_hold, llu_ready, dec_stall,
        output rf_regwrite, rf_addr_write, rf_data_in
    );

endinterface

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO for pending LLU register writes.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   push/din : write an entry (ignored when full unless popping in the same cycle)
//   pop/dout : dout is the head; pop removes it (ignored when empty)
//   full, empty, count : occupancy, all derived from the registered count
module rf_wb_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic [7:0],
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  T              din,
    input  logic          pop,
    output T              dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer wrap that also works for non-power-of-two depths.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Owner of the single register-file write port.
// Shares the port between the in-order WB stage (priority) and a long-latency
// unit whose results queue in a small FIFO. A starvation FSM forces one drain
// slot after STARVE_MAX consecutive denied cycles. A busy scoreboard tracks LLU
// destinations and stalls decode on any hazard.
//   clk, rst : clock, synchronous active-high reset
//   bus      : rf_wb_arbiter_if.slave (WB, LLU issue/result, decode, RF port)
// Parameters: FIFO_DEPTH (LLU result entries, >=1), STARVE_MAX (denied cycles
// before wb_hold). Data width is rf_pkg::XLEN.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    rf_wb_arbiter_if.slave bus
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    wr_req_t           llu_req;
    wr_req_t           head;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;

    logic              force_slot;
    logic              grant_fifo;
    logic              grant_wb;
    logic [REG_AW-1:0] wr_rd;

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [SW-1:0]     starve_q;
    logic [SW-1:0]     starve_d;
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   busy_d;

    // ---------------------------------------------------------------
    // LLU result buffer
    // ---------------------------------------------------------------
    assign llu_req.rd   = bus.llu_rd;
    assign llu_req.data = bus.llu_data;

    // llu_ready comes from the registered count only, so a pop this cycle
    // re-opens the FIFO to the LLU on the following cycle.
    assign push = !rst && bus.llu_valid && !full;
    assign pop  = grant_fifo;

    rf_wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (wr_req_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (llu_req),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (cnt)
    );

    // ---------------------------------------------------------------
    // Write-port grant (combinational, so the RF captures it on the
    // falling edge of the same cycle)
    // ---------------------------------------------------------------
    assign force_slot = (state_q == FORCE) && !empty;
    assign grant_fifo = !rst && !empty && (force_slot || !bus.wb_valid);
    assign grant_wb   = !rst && !force_slot && bus.wb_valid;

    assign wr_rd             = grant_fifo ? head.rd : bus.wb_rd;
    assign bus.rf_addr_write = wr_rd;
    assign bus.rf_data_in    = grant_fifo ? head.data : bus.wb_data;
    // x0 writes still consume the slot (and pop the FIFO) but never reach the RF.
    assign bus.rf_regwrite   = (grant_fifo || grant_wb) && (wr_rd != '0);

    assign bus.wb_hold   = !rst && (state_q == FORCE);
    assign bus.llu_ready = !rst && !full;
    assign bus.dec_stall = !rst && (reg_busy(busy_q, bus.dec_rs1) ||
                                    reg_busy(busy_q, bus.dec_rs2) ||
                                    reg_busy(busy_q, bus.dec_rd));

    // ---------------------------------------------------------------
    // Starvation FSM
    // ---------------------------------------------------------------
    always_comb begin
        cnt_nxt  = cnt + CW'(push) - CW'(pop);

        // Counts consecutive cycles in which a waiting head lost the port.
        starve_d = '0;
        if (!empty && !grant_fifo) begin
            starve_d = (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + 1'b1;
        end

        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cnt_nxt != '0) state_d = WAIT;
            end
            WAIT: begin
                if (cnt_nxt == '0)                      state_d = IDLE;
                else if (starve_d == SW'(STARVE_MAX))   state_d = FORCE;
            end
            FORCE: begin
                // The head always drains in FORCE, so stay only one cycle.
                state_d = (cnt_nxt != '0) ? WAIT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // ---------------------------------------------------------------
    // Busy scoreboard for LLU destinations
    // ---------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        if (grant_fifo) busy_d[head.rd] = 1'b0;
        // Applied after the clear: a new issue to the same rd keeps it busy.
        if (bus.iss_valid && (bus.iss_rd != '0)) busy_d[bus.iss_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

endmodule
